conv_encoder_k7: RTL

CONV_ENCODER_K7 -- requirements
Module: conv_encoder_k7

---
 rtl/conv_encoder_k7.sv | 109 ++++++++++
 1 files changed

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 feed-forward convolutional encoder with valid/ready handshake
// on both sides and optional six-bit zero tail per frame.
module conv_encoder_k7 #(
    parameter logic [6:0] G0      = 7'o171,
    parameter logic [6:0] G1      = 7'o133,
    parameter bit         TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t     state_q, state_d;
    logic [5:0] sr_q, sr_d;
    logic [2:0] tail_cnt_q, tail_cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_pair_q, out_pair_d;
    logic       out_last_q, out_last_d;
    logic       slot_free;
    logic       accept;

    // Generator MSB taps the bit being encoded, LSB taps the oldest bit sr[5].
    function automatic logic [1:0] parity(input logic b, input logic [5:0] sr);
        logic [6:0] v;
        v[6] = b;
        for (int unsigned i = 0; i < 6; i++) begin
            v[5 - i] = sr[i];
        end
        return {^(v & G1), ^(v & G0)};
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q != TAIL) && slot_free;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_pair_d  = parity(in_bit, sr_q);
            out_last_d  = in_last && !TAIL_EN;
            sr_d        = {sr_q[4:0], in_bit};
            if (in_last) begin
                tail_cnt_d = '0;
                if (TAIL_EN) begin
                    state_d = TAIL;
                end else begin
                    state_d = IDLE;
                    sr_d    = '0;
                end
            end else begin
                state_d = DATA;
            end
        end else if (state_q == TAIL && slot_free) begin
            out_valid_d = 1'b1;
            out_pair_d  = parity(1'b0, sr_q);
            out_last_d  = (tail_cnt_q == 3'd5);
            sr_d        = {sr_q[4:0], 1'b0};
            if (tail_cnt_q == 3'd5) begin
                state_d    = IDLE;
                tail_cnt_d = '0;
                sr_d       = '0;
            end else begin
                tail_cnt_d = tail_cnt_q + 3'd1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_pair_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_pair_q  <= out_pair_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE) || out_valid_q;

endmodule
